go_cdc_multi: RTL and testbench
===============================

// Module: go_cdc_multi
// PURPOSE
//  Multi-channel handshaked pulse synchroniser. It carries single-cycle "go" events from clk_i to clk_o.
//  Each channel uses a toggle req/ack loop, so an event is never lost while another is in flight.
//  Events that arrive while a channel is busy are queued in a saturating counter and relaunched automatically.
//  Used between the controller domain and the compute-array domain of the CNN engine.
// PARAMETERS
//  NCH          4   number of independent channels
//  SYNC_STAGES  2   synchroniser flops per crossing, both directions; legal range 2..4
//  PEND_W       2   pending-counter width; at most 2^PEND_W-1 queued events per channel
// PORTS
//  clk_i      in   1    source clock
//  rstn_i     in   1    source reset, asynchronous, active-low
//  clk_o      in   1    destination clock
//  rstn_o     in   1    destination reset, asynchronous, active-low
//  go_i       in   NCH  source event pulses, one clk_i cycle each
//  clr_ovf_i  in   NCH  clk_i domain; clears ovf_o[c]
//  busy_o     out  NCH  clk_i domain; 1 = channel has a handshake in flight
//  ovf_o      out  NCH  clk_i domain; sticky flag, an event was dropped
//  go_o       out  NCH  clk_o domain; delivered event pulse, one clk_o cycle
// BEHAVIOUR
//  Reset values: busy_o=0, ovf_o=0, go_o=0. All toggles, synchronisers and counters are 0.
//  Channel state in the source domain:
//   - req toggle
//   - ack synchroniser, SYNC_STAGES flops, last flop = ack_s
//   - pend counter, PEND_W bits
//   - ovf flag
//  busy_o[c] = (req != ack_s). It is derived from flops only and is glitch-free.
//  Launch, per clk_i edge:
//   - launch = (!busy & go_i) | (!busy & pend!=0).
//   - On launch, req flips on that edge.
//  pend update:
//   - go_i & busy & pend<MAX -> pend+1.
//   - go_i & busy & pend==MAX -> pend unchanged; ovf set.
//   - !busy & pend!=0 & !go_i -> pend-1 (the pending event is launched).
//   - !busy & pend!=0 & go_i -> pend unchanged (one launched, one queued).
//   - !busy & pend==0 & go_i -> launch directly; pend stays 0.
//  ovf: set by overflow, cleared by clr_ovf_i. If set and clear occur on the same edge, set wins.
//  Destination side, per channel:
//   - req synchroniser, SYNC_STAGES flops, last flop = req_s
//   - flop p1 <= req_s
//   - go_o[c] = req_s ^ p1 (combinational from flops; exactly one clk_o cycle wide)
//   - ack toggle = p1, returned through the ack synchroniser into clk_i
//  Forward latency: req flips at clk_i edge T.
//   - go_o rises after the SYNC_STAGES-th clk_o edge following T.
//   - go_o is held for one clk_o cycle.
//   - Metastability adds up to +1 clk_o edge.
//  Round trip from launch to busy_o=0: about (SYNC_STAGES+1) clk_o + SYNC_STAGES clk_i cycles, plus up to 1 of each.
//  Minimum spacing between successive go_o pulses on one channel = that round trip. No go_o pulses are merged.
//  Channels are fully independent. Any go_i pattern across channels is legal on any cycle.
//  Clock ratio: no constraint in either direction, because the handshake makes the crossing rate-independent.
//  Resets:
//   - rstn_i and rstn_o must overlap; system reset guarantees this.
//   - A reset mid-handshake discards in-flight and pending events.
//   - After reset release: no spurious go_o and no stuck busy_o.
//   - Independent single-domain reset is unsupported and may produce a spurious go_o.
//  Only single-bit toggles cross domains. Synchroniser flops carry an ASYNC_REG attribute.
// TESTING (NCH=4, SYNC_STAGES=2, PEND_W=2)
//  1. Single go_i[0] -> exactly one go_o[0], 1 clk_o wide, rising 2-3 clk_o edges after req flips.
//     busy_o[0] is 1 from the next clk_i edge until the ack returns.
//  2. Three back-to-back go_i[1] pulses -> exactly three go_o[1] pulses, each one round trip apart. ovf_o[1]=0.
//  3. Six go_i[2] pulses while busy -> four go_o[2] pulses in total (1 + pend max 3). ovf_o[2]=1.
//     clr_ovf_i[2] then returns ovf_o[2] to 0.
//  4. go_i[3] on the same edge busy_o[3] falls, with pend=1 -> launch occurs, pend stays 1, two further go_o[3] follow.
//  5. All channels pulse together at clk_i/clk_o ratios 100/37 and 37/100 MHz -> each channel's go_o count equals its go_i count. No crosstalk.
//  6. Both resets asserted mid-handshake with pend=2 -> all outputs 0.
//     After release: no go_o without new stimulus.

Source files
------------

// File: rtl/go_cdc_multi.sv
// ---------------------------------------------------------------------------
// go_cdc_multi
//
// Multi-channel handshaked pulse synchroniser. Single-cycle "go" events in
// the clk_i domain are carried to single-cycle pulses in the clk_o domain.
//
// Each channel runs a toggle req/ack loop. Only one event per channel is in
// flight at a time. Events that arrive while a channel is busy are queued in
// a saturating counter and relaunched automatically when the ack returns.
// Events beyond the counter's capacity are dropped and latched in a sticky
// overflow flag.
//
// Sits between the controller domain (clk_i) and the compute-array domain
// (clk_o) of the CNN engine.
//
// Parameters
//   NCH          number of independent channels
//   SYNC_STAGES  synchroniser depth in both directions, legal range 2..4
//   PEND_W       pending-counter width, up to 2^PEND_W-1 queued events
//
// Ports
//   clk_i      source clock
//   rstn_i     source reset, asynchronous, active-low
//   clk_o      destination clock
//   rstn_o     destination reset, asynchronous, active-low
//   go_i       [NCH] source event pulses, one clk_i cycle each
//   clr_ovf_i  [NCH] clk_i domain, clears ovf_o per channel
//   busy_o     [NCH] clk_i domain, handshake in flight
//   ovf_o      [NCH] clk_i domain, sticky "an event was dropped"
//   go_o       [NCH] clk_o domain, delivered event pulse, one clk_o cycle
// ---------------------------------------------------------------------------
module go_cdc_multi #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 2
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           clk_o,
  input  logic           rstn_o,
  input  logic [NCH-1:0] go_i,
  input  logic [NCH-1:0] clr_ovf_i,
  output logic [NCH-1:0] busy_o,
  output logic [NCH-1:0] ovf_o,
  output logic [NCH-1:0] go_o
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  for (genvar c = 0; c < NCH; c++) begin : g_ch

    // Source-domain state
    logic                    r_req;
    (* ASYNC_REG = "TRUE" *)
    logic [SYNC_STAGES-1:0]  r_ackSync;
    logic [PEND_W-1:0]       r_pend;
    logic                    r_ovf;

    // Destination-domain state
    (* ASYNC_REG = "TRUE" *)
    logic [SYNC_STAGES-1:0]  r_reqSync;
    logic                    r_p1;

    logic                    w_ackS;
    logic                    w_reqS;
    logic                    w_busy;
    logic                    w_pendNz;
    logic                    w_launch;
    logic                    w_ovfSet;
    logic [PEND_W-1:0]       w_pendNext;

    assign w_ackS   = r_ackSync[SYNC_STAGES-1];
    assign w_reqS   = r_reqSync[SYNC_STAGES-1];

    // A channel is busy while the returned ack has not caught up with req.
    // Both operands are flops, so busy_o cannot glitch.
    assign w_busy   = r_req ^ w_ackS;
    assign w_pendNz = (r_pend != '0);

    // A launch needs an idle channel and either a fresh or a queued event.
    // When both are present, one goes out and the other takes its place in
    // the queue, so the counter is left alone in that case.
    assign w_launch = ~w_busy & (go_i[c] | w_pendNz);

    always_comb begin
      w_pendNext = r_pend;
      w_ovfSet   = 1'b0;
      if (w_busy) begin
        if (go_i[c]) begin
          if (r_pend != PEND_MAX) begin
            w_pendNext = r_pend + 1'b1;
          end else begin
            w_ovfSet = 1'b1;
          end
        end
      end else if (w_pendNz && !go_i[c]) begin
        w_pendNext = r_pend - 1'b1;
      end
    end

    // Source side: req toggle, queue counter and sticky overflow flag.
    // An overflow on the same edge as a clear keeps the flag set so the
    // dropped event is never hidden.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_req  <= 1'b0;
        r_pend <= '0;
        r_ovf  <= 1'b0;
      end else begin
        if (w_launch) begin
          r_req <= ~r_req;
        end
        r_pend <= w_pendNext;
        r_ovf  <= w_ovfSet | (r_ovf & ~clr_ovf_i[c]);
      end
    end

    // Ack toggle (p1) brought back into clk_i.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        r_ackSync <= '0;
      end else begin
        r_ackSync <= {r_ackSync[SYNC_STAGES-2:0], r_p1};
      end
    end

    // Req toggle brought into clk_o. p1 trails req_s by one cycle; their
    // difference is the delivered pulse and p1 itself doubles as the ack.
    always_ff @(posedge clk_o or negedge rstn_o) begin
      if (!rstn_o) begin
        r_reqSync <= '0;
        r_p1      <= 1'b0;
      end else begin
        r_reqSync <= {r_reqSync[SYNC_STAGES-2:0], r_req};
        r_p1      <= w_reqS;
      end
    end

    assign busy_o[c] = w_busy;
    assign ovf_o[c]  = r_ovf;
    assign go_o[c]   = w_reqS ^ r_p1;

  end : g_ch

endmodule

// File: tb/tb_go_cdc_multi.sv
// ---------------------------------------------------------------------------
// tb_go_cdc_multi
//
// Directed bench for go_cdc_multi with NCH=4, SYNC_STAGES=2, PEND_W=2.
// Delivered go_o pulses are counted per channel on the falling edge of
// clk_o, together with the smallest spacing seen between pulses.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_go_cdc_multi;

  logic       clk_i = 1'b0;
  logic       clk_o = 1'b0;
  logic       rstn_i;
  logic       rstn_o;
  logic [3:0] go_i;
  logic [3:0] clr_ovf_i;
  logic [3:0] busy_o;
  logic [3:0] ovf_o;
  logic [3:0] go_o;

  realtime srcHalf = 5.0;
  realtime dstHalf = 15.5;

  int checks   = 0;
  int failures = 0;

  int edgeO = 0;
  int goCount  [4] = '{0, 0, 0, 0};
  int lastEdge [4] = '{-1000, -1000, -1000, -1000};
  int minGap   [4] = '{1000, 1000, 1000, 1000};
  int snap     [4];

  logic [3:0] burst [7] = '{4'b1111, 4'b0110, 4'b1001, 4'b0000,
                            4'b1100, 4'b0011, 4'b0001};
  int burstExp [4] = '{4, 3, 3, 3};

  go_cdc_multi #(
    .NCH(4),
    .SYNC_STAGES(2),
    .PEND_W(2)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .clk_o(clk_o),
    .rstn_o(rstn_o),
    .go_i(go_i),
    .clr_ovf_i(clr_ovf_i),
    .busy_o(busy_o),
    .ovf_o(ovf_o),
    .go_o(go_o)
  );

  // Clocks with run-time adjustable half periods
  always #(srcHalf) clk_i = ~clk_i;
  always #(dstHalf) clk_o = ~clk_o;

  // Running count of clk_o rising edges, used as a time base for latency
  always @(posedge clk_o) edgeO++;

  // Pulse counter and spacing monitor, sampled mid-cycle of clk_o
  always @(negedge clk_o) begin
    for (int c = 0; c < 4; c++) begin
      if (go_o[c] === 1'b1) begin
        if (edgeO - lastEdge[c] < minGap[c]) minGap[c] = edgeO - lastEdge[c];
        lastEdge[c] = edgeO;
        goCount[c]  = goCount[c] + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Hold mask on go_i for the given number of clk_i cycles
  task automatic applyStimulus(input logic [3:0] mask, input int cycles);
    @(negedge clk_i);
    go_i = mask;
    repeat (cycles) @(negedge clk_i);
    go_i = '0;
  endtask

  // Wait until every channel has stayed idle for four clk_i cycles
  task automatic waitIdle(input string tag, input int budget);
    int stable = 0;
    for (int i = 0; i < budget && stable < 4; i++) begin
      @(negedge clk_i);
      if (busy_o === 4'b0000) stable++;
      else stable = 0;
    end
    checkOutput(tag, 32'(stable >= 4), 32'd1);
  endtask

  task automatic takeSnap();
    for (int c = 0; c < 4; c++) snap[c] = goCount[c];
  endtask

  initial begin
    int launchEdge;
    int riseEdge;
    int found;

    go_i      = '0;
    clr_ovf_i = '0;
    rstn_i    = 1'b0;
    rstn_o    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_i);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_ovf",  32'(ovf_o),  32'd0);
    checkOutput("rst_go",   32'(go_o),   32'd0);
    rstn_i = 1'b1;
    rstn_o = 1'b1;
    repeat (10) @(negedge clk_i);
    checkOutput("post_rst_go_count", 32'(goCount[0] + goCount[1] + goCount[2] + goCount[3]), 32'd0);

    // 1. Single event on channel 0: latency, busy window, one pulse
    $display("[TB] test 1: single event");
    takeSnap();
    @(negedge clk_i);
    checkOutput("t1_busy_before", 32'(busy_o[0]), 32'd0);
    go_i = 4'b0001;
    @(posedge clk_i);
    launchEdge = edgeO;
    @(negedge clk_i);
    go_i = '0;
    checkOutput("t1_busy_after", 32'(busy_o[0]), 32'd1);
    found = 0;
    riseEdge = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk_o);
      if (go_o[0] === 1'b1) begin
        found = 1;
        riseEdge = edgeO;
      end
    end
    checkOutput("t1_go_seen", 32'(found), 32'd1);
    checkOutput("t1_latency_2to3",
                32'((riseEdge - launchEdge >= 2) && (riseEdge - launchEdge <= 3)), 32'd1);
    waitIdle("t1_idle", 200);
    checkOutput("t1_count", 32'(goCount[0] - snap[0]), 32'd1);

    // 2. Three back-to-back events on channel 1
    $display("[TB] test 2: back-to-back events");
    takeSnap();
    applyStimulus(4'b0010, 3);
    waitIdle("t2_idle", 300);
    checkOutput("t2_count", 32'(goCount[1] - snap[1]), 32'd3);
    checkOutput("t2_ovf", 32'(ovf_o[1]), 32'd0);
    checkOutput("t2_spacing", 32'(minGap[1] >= 3), 32'd1);

    // 3. One launch plus six more while busy on channel 2: three queued,
    //    three dropped
    $display("[TB] test 3: overflow");
    takeSnap();
    applyStimulus(4'b0100, 7);
    checkOutput("t3_ovf_set", 32'(ovf_o[2]), 32'd1);
    waitIdle("t3_idle", 400);
    checkOutput("t3_count", 32'(goCount[2] - snap[2]), 32'd4);
    checkOutput("t3_ovf_sticky", 32'(ovf_o[2]), 32'd1);
    @(negedge clk_i);
    clr_ovf_i = 4'b0100;
    @(negedge clk_i);
    clr_ovf_i = '0;
    checkOutput("t3_ovf_clr", 32'(ovf_o[2]), 32'd0);

    // 4. New event on the first idle edge while one event is still queued
    $display("[TB] test 4: go while draining queue");
    takeSnap();
    applyStimulus(4'b1000, 2);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk_i);
      if (busy_o[3] === 1'b0) found = 1;
    end
    checkOutput("t4_busy_fell", 32'(found), 32'd1);
    go_i = 4'b1000;
    @(negedge clk_i);
    go_i = '0;
    checkOutput("t4_relaunch", 32'(busy_o[3]), 32'd1);
    waitIdle("t4_idle", 400);
    checkOutput("t4_count", 32'(goCount[3] - snap[3]), 32'd3);

    // 5. All channels together at 100/37 and 37/100 MHz
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin
        srcHalf = 5.0;
        dstHalf = 13.514;
      end else begin
        srcHalf = 13.514;
        dstHalf = 5.0;
      end
      $display("[TB] test 5: clock ratio set %0d", r);
      repeat (5) @(negedge clk_i);
      takeSnap();
      for (int v = 0; v < 7; v++) begin
        @(negedge clk_i);
        go_i = burst[v];
      end
      @(negedge clk_i);
      go_i = '0;
      waitIdle("t5_idle", 400);
      for (int c = 0; c < 4; c++) begin
        checkOutput($sformatf("t5_r%0d_count_ch%0d", r, c),
                    32'(goCount[c] - snap[c]), 32'(burstExp[c]));
      end
      checkOutput("t5_ovf", 32'(ovf_o), 32'd0);
    end

    // 6. Both resets mid-handshake with events queued
    $display("[TB] test 6: reset mid-handshake");
    srcHalf = 5.0;
    dstHalf = 15.5;
    repeat (5) @(negedge clk_i);
    @(negedge clk_i);
    go_i = 4'b0011;
    repeat (3) @(negedge clk_i);
    go_i = 4'b0010;
    repeat (3) @(negedge clk_i);
    go_i = '0;
    checkOutput("t6_ovf_before", 32'(ovf_o[1]), 32'd1);
    checkOutput("t6_busy_before", 32'(busy_o[0]), 32'd1);
    rstn_i = 1'b0;
    rstn_o = 1'b0;
    takeSnap();
    #1;
    checkOutput("t6_rst_busy", 32'(busy_o), 32'd0);
    checkOutput("t6_rst_ovf",  32'(ovf_o),  32'd0);
    checkOutput("t6_rst_go",   32'(go_o),   32'd0);
    repeat (4) @(negedge clk_i);
    rstn_i = 1'b1;
    rstn_o = 1'b1;
    repeat (60) @(negedge clk_i);
    checkOutput("t6_busy_after", 32'(busy_o), 32'd0);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("t6_no_go_ch%0d", c), 32'(goCount[c] - snap[c]), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
